// File: rtl/seq_comp_pkg.sv
// Shared types and sizing helpers for the sequential magnitude comparator.
package seq_comp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [1:0] RES_EQ = 2'b00;
    localparam logic [1:0] RES_GT = 2'b01;
    localparam logic [1:0] RES_LT = 2'b10;

    function automatic int calc_nchunk(input int dw, input int ch);
        return dw / ch;
    endfunction

    // Chunk index needs at least one bit even when there is a single chunk.
    function automatic int calc_idx_w(input int dw, input int ch);
        int n;
        n = dw / ch;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_comp_chunk.sv
// Combinational unsigned compare of one CHUNK-bit slice of each operand.
module comp_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_chunk,
    input  logic [CHUNK-1:0] b_chunk,
    output logic             chunk_gt,
    output logic             chunk_lt
);

    assign chunk_gt = (a_chunk > b_chunk);
    assign chunk_lt = (a_chunk < b_chunk);

endmodule

// File: rtl/seq_comp.sv
// Handshaked multi-cycle magnitude comparator, CHUNK bits per cycle from the MSB down.
// Optional: define SEQ_COMP_EARLY_EXIT_EN to finish on the first differing chunk.
module seq_comp
    import seq_comp_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int CHUNK     = 4
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    input  logic                 is_signed,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 gt,
    output logic                 lt,
    output logic                 eq
);

    localparam int NCHUNK = calc_nchunk(DATAWIDTH, CHUNK);
    localparam int IDXW   = calc_idx_w(DATAWIDTH, CHUNK);
    localparam logic [IDXW-1:0]      LAST_IDX = IDXW'(NCHUNK - 1);
    localparam logic [DATAWIDTH-1:0] MSB_MASK = DATAWIDTH'(1) << (DATAWIDTH - 1);

    if (CHUNK < 1 || CHUNK > DATAWIDTH || (DATAWIDTH % CHUNK) != 0) begin : g_bad_cfg
        $error("seq_comp: DATAWIDTH must be a positive multiple of CHUNK");
    end

    state_t                 state_reg, state_next;
    logic [DATAWIDTH-1:0]   a_sh_reg, b_sh_reg;
    logic [IDXW-1:0]        idx_reg;
    logic                   decided_reg;
    logic [1:0]             res_reg;
    logic                   chunk_gt, chunk_lt, chunk_diff, last_chunk;

    comp_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a_chunk  (a_sh_reg[DATAWIDTH-1 -: CHUNK]),
        .b_chunk  (b_sh_reg[DATAWIDTH-1 -: CHUNK]),
        .chunk_gt (chunk_gt),
        .chunk_lt (chunk_lt)
    );

    assign chunk_diff = chunk_gt | chunk_lt;
    assign last_chunk = (idx_reg == LAST_IDX);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = COMPARE;
            end
            COMPARE: begin
                if (last_chunk) state_next = DONE;
`ifdef SEQ_COMP_EARLY_EXIT_EN
                if (!decided_reg && chunk_diff) state_next = DONE;
`endif
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Signed mode flips both MSBs so the unsigned chunk compare yields the signed order.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            a_sh_reg    <= '0;
            b_sh_reg    <= '0;
            idx_reg     <= '0;
            decided_reg <= 1'b0;
            res_reg     <= RES_EQ;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_sh_reg    <= a ^ (is_signed ? MSB_MASK : '0);
                        b_sh_reg    <= b ^ (is_signed ? MSB_MASK : '0);
                        idx_reg     <= '0;
                        decided_reg <= 1'b0;
                        res_reg     <= RES_EQ;
                    end
                end
                COMPARE: begin
                    if (!decided_reg && chunk_diff) begin
                        decided_reg <= 1'b1;
                        res_reg     <= chunk_gt ? RES_GT : RES_LT;
                    end
                    a_sh_reg <= a_sh_reg << CHUNK;
                    b_sh_reg <= b_sh_reg << CHUNK;
                    idx_reg  <= idx_reg + IDXW'(1);
                end
                default: ;
            endcase
        end
    end

    assign gt = (state_reg == DONE) && (res_reg == RES_GT);
    assign lt = (state_reg == DONE) && (res_reg == RES_LT);
    assign eq = (state_reg == DONE) && (res_reg == RES_EQ);

endmodule
